multiply_acc_ctrl: RTL and testbench

Sequencing controller for one `multiply_acc` datapath instance. It takes a job of N image/kernel term pairs over a valid/ready stream and clears the accumulator before the job. It feeds the terms with `val` qualification, waits out the MAC pipeline latency, then captures the dot-product and presents it on a valid/ready output. It sits between the convolution window/kernel fetch logic and the MAC, one controller per MAC lane.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/multiply_acc_ctrl.sv | 150 +++++++++++++++
 tb/tb_multiply_acc_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath blocks.
//   macc_state_t         : state encoding of the multiply_acc sequencing controller
//   MACC_LATENCY_DEFAULT : cycles from a MAC val cycle to its product showing on the
//                          accumulator output; shared with the MAC array top
package cnn_pkg;

    typedef enum logic [2:0] {
        MACC_IDLE   = 3'd0,
        MACC_CLEAR  = 3'd1,
        MACC_ACCUM  = 3'd2,
        MACC_DRAIN  = 3'd3,
        MACC_OUTPUT = 3'd4
    } macc_state_t;

    localparam int MACC_LATENCY_DEFAULT = 5;

endpackage

// File: rtl/multiply_acc_ctrl.sv
// Sequencing controller for one multiply_acc lane.
// Accepts a job of cfg_len image/kernel pairs, clears the MAC, streams the pairs
// into it, waits out the MAC pipeline latency and then holds the captured
// dot-product on a valid/ready output until it is taken.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_start, cfg_len        job start and term count (sampled in IDLE only)
//   busy                      high whenever the controller is not IDLE
//   in_img, in_ker            term pair, in_valid/in_ready handshake
//   mac_img, mac_ker, mac_val combinational pass-through to the MAC
//   mac_rst                   MAC clear (system reset or CLEAR state)
//   mac_result                MAC accumulator output
//   out_data, out_valid       captured result, out_ready handshake
module multiply_acc_ctrl
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH   = 16,
    parameter int KER_WIDTH   = 16,
    parameter int LEN_WIDTH   = 12,
    parameter int MAC_LATENCY = MACC_LATENCY_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic [LEN_WIDTH-1:0]           cfg_len,
    output logic                           busy,
    input  logic [IMG_WIDTH-1:0]           in_img,
    input  logic [KER_WIDTH-1:0]           in_ker,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [IMG_WIDTH-1:0]           mac_img,
    output logic [KER_WIDTH-1:0]           mac_ker,
    output logic                           mac_val,
    output logic                           mac_rst,
    input  logic [IMG_WIDTH+KER_WIDTH:0]   mac_result,
    output logic [IMG_WIDTH+KER_WIDTH:0]   out_data,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int RES_W   = IMG_WIDTH + KER_WIDTH + 1;
    localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    // The drain counter counts down to zero, so DRAIN lasts DRAIN_LOAD+1 cycles.
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MAC_LATENCY - 1);

    macc_state_t            state_reg;
    macc_state_t            state_next;
    logic [LEN_WIDTH-1:0]   len_reg;
    logic [LEN_WIDTH-1:0]   cnt_reg;
    logic [DRAIN_W-1:0]     drain_reg;
    logic [RES_W-1:0]       out_data_reg;
    logic                   clear;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MACC_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        clear      = 1'b0;
        case (state_reg)
            MACC_IDLE: begin
                busy = 1'b0;
                if (cfg_start) begin
                    state_next = MACC_CLEAR;
                end
            end
            MACC_CLEAR: begin
                clear      = 1'b1;
                state_next = (len_reg == '0) ? MACC_DRAIN : MACC_ACCUM;
            end
            MACC_ACCUM: begin
                in_ready = 1'b1;
                // cnt_reg < len_reg here, so the increment cannot wrap.
                if (in_valid && (cnt_reg + 1'b1 == len_reg)) begin
                    state_next = MACC_DRAIN;
                end
            end
            MACC_DRAIN: begin
                if (drain_reg == '0) begin
                    state_next = MACC_OUTPUT;
                end
            end
            MACC_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = MACC_IDLE;
                end
            end
            default: begin
                state_next = MACC_IDLE;
            end
        endcase
    end

    // Job length, term counter, drain counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg      <= '0;
            cnt_reg      <= '0;
            drain_reg    <= '0;
            out_data_reg <= '0;
        end else begin
            case (state_reg)
                MACC_IDLE: begin
                    if (cfg_start) begin
                        len_reg <= cfg_len;
                        cnt_reg <= '0;
                    end
                end
                MACC_CLEAR: begin
                    drain_reg <= DRAIN_LOAD;
                end
                MACC_ACCUM: begin
                    drain_reg <= DRAIN_LOAD;
                    if (mac_val) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                MACC_DRAIN: begin
                    if (drain_reg == '0) begin
                        // The last accepted product is visible on mac_result now.
                        out_data_reg <= mac_result;
                    end else begin
                        drain_reg <= drain_reg - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mac_img  = in_img;
    assign mac_ker  = in_ker;
    assign mac_val  = in_valid & in_ready;
    assign mac_rst  = rst | clear;
    assign out_data = out_data_reg;

endmodule

// File: tb/tb_multiply_acc_ctrl.sv
module tb_multiply_acc_ctrl;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [11:0] cfg_len;
    logic        busy;
    logic [15:0] in_img;
    logic [15:0] in_ker;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mac_img;
    logic [15:0] mac_ker;
    logic        mac_val;
    logic        mac_rst;
    logic [32:0] mac_result;
    logic [32:0] out_data;
    logic        out_valid;
    logic        out_ready;

    multiply_acc_ctrl #(
        .IMG_WIDTH(16), .KER_WIDTH(16), .LEN_WIDTH(12), .MAC_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .busy(busy),
        .in_img(in_img), .in_ker(in_ker), .in_valid(in_valid), .in_ready(in_ready),
        .mac_img(mac_img), .mac_ker(mac_ker), .mac_val(mac_val), .mac_rst(mac_rst),
        .mac_result(mac_result), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in MAC: LAT-1 product stages plus the accumulator register.
    logic [32:0] pipe [LAT-1];
    logic [32:0] acc;
    assign mac_result = acc;
    always @(posedge clk) begin
        if (mac_rst) begin
            for (int k = 0; k < LAT - 1; k++) pipe[k] <= '0;
            acc <= '0;
        end else begin
            pipe[0] <= mac_val ? 33'($signed(mac_img) * $signed(mac_ker)) : 33'd0;
            for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
            acc <= acc + pipe[LAT-2];
        end
    end

    typedef struct {
        logic [32:0] data;
        int          vcyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int hold_req = 0;
    int img_a [16];
    int ker_a [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain dot product, wrapped to the 33-bit accumulator width.
    function automatic logic [32:0] dot(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(img_a[i]) * longint'(ker_a[i]);
        return 33'(s);
    endfunction

    // Consumer side: out_ready is held low for hold_req cycles, otherwise random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_req > 0) begin
                out_ready = 1'b0;
                if (out_valid) hold_req--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: compares each presented result against the scoreboard.
    logic        ov_prev = 1'b0;
    logic [32:0] held;
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid) begin
                chk("pass_img", 64'(mac_img), 64'(in_img));
                chk("pass_ker", 64'(mac_ker), 64'(in_ker));
            end
            if (out_valid) begin
                if (!ov_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=%0h required=none", out_data);
                    end else begin
                        chk("latency", 64'(cyc), 64'(sb[0].vcyc));
                        chk("result", 64'(out_data), 64'(sb[0].data));
                    end
                    held = out_data;
                end else begin
                    chk("hold_data", 64'(out_data), 64'(held));
                    chk("hold_busy", 64'(busy), 64'd1);
                end
                if (out_ready && sb.size() > 0) begin
                    $display("job done cycle=%0d result=%0d", cyc, $signed(out_data));
                    void'(sb.pop_front());
                end
            end
        end
        ov_prev = out_valid;
    end

    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        $display("FAIL wait_idle actual=busy required=idle");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    endtask

    // Runs one job from img_a/ker_a. A stall of stall_len cycles is inserted before
    // term stall_at; abort_at >= 0 pulses rst after that many accepted terms.
    task automatic run_job(input int n, input int stall_at, input int stall_len,
                           input bit spurious, input int abort_at);
        int s;
        bit ok;
        wait_idle();
        @(posedge clk);
        #1;
        cfg_start = 1'b1;
        cfg_len   = 12'(n);
        s = cyc;
        if (abort_at < 0) sb.push_back('{dot(n), s + 2 + n + stall_len + LAT});
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        if (n == 0) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (out_valid) break;
                chk("len0_in_ready", 64'(in_ready), 64'd0);
            end
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                chk("rst_mac_rst", 64'(mac_rst), 64'd1);
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd0);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_data", 64'(out_data), 64'd0);
                chk("rst_mac_rst_after", 64'(mac_rst), 64'd0);
                return;
            end
            if (i == stall_at && stall_len > 0) begin
                in_valid = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            in_img   = 16'(img_a[i]);
            in_ker   = 16'(ker_a[i]);
            in_valid = 1'b1;
            cfg_start = spurious && (i == 1);
            cfg_len   = 12'd7;
            ok = 1'b0;
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                cfg_start = 1'b0;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=0 required=1 term=%0d", i);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic set_pairs(input int n, input int v);
        for (int i = 0; i < n; i++) begin
            img_a[i] = v;
            ker_a[i] = v;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_len = '0;
        in_img = '0; in_ker = '0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_mac_val", 64'(mac_val), 64'd0);
        chk("reset_mac_rst", 64'(mac_rst), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 3-term job, no stalls: 27
        img_a[0] = 2;  ker_a[0] = 3;
        img_a[1] = -1; ker_a[1] = 4;
        img_a[2] = 5;  ker_a[2] = 5;
        run_job(3, 0, 0, 1'b0, -1);
        // same job, 4-cycle gap after the first term, with a spurious cfg_start
        run_job(3, 1, 4, 1'b1, -1);
        // empty job
        run_job(0, 0, 0, 1'b0, -1);
        // back-to-back jobs, second result held for 3 cycles
        img_a[0] = 7; ker_a[0] = 7;
        run_job(1, 0, 0, 1'b0, -1);
        img_a[0] = 1; ker_a[0] = -2;
        hold_req = 3;
        run_job(1, 0, 0, 1'b0, -1);
        // most-negative operands: 3 * 2^30 without wrap
        set_pairs(3, -32768);
        run_job(3, 0, 0, 1'b0, -1);
        // reset after two accepted terms, then a fresh job
        set_pairs(5, 6);
        run_job(5, 0, 0, 1'b0, 2);
        img_a[0] = 3; ker_a[0] = 3;
        run_job(1, 0, 0, 1'b0, -1);

        // randomized jobs
        for (int j = 0; j < 14; j++) begin
            int n;
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                img_a[i] = int'($signed(16'($urandom)));
                ker_a[i] = int'($signed(16'($urandom)));
            end
            hold_req = $urandom_range(0, 2);
            run_job(n, (n > 1) ? $urandom_range(1, n - 1) : 0,
                    (n > 1) ? $urandom_range(0, 3) : 0, 1'($urandom_range(0, 1)), -1);
        end

        wait_idle();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
